// File: rtl/class6_weight_enum.sv
// Purpose : streams every N-bit word whose popcount equals a requested weight k, in ascending order.
// Latency : first word valid one cycle after the request is accepted; one word per cycle after that.
// Backpressure: out_word/out_last hold while out_ready=0; requests are only accepted in IDLE.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready is a decode of the state register)
//   req_weight          target weight k; k > N is rejected with a one-cycle err pulse
//   out_valid/out_ready output word handshake
//   out_word            current word, popcount equals the latched k
//   out_last            marks the final (largest) word of the enumeration
//   busy                enumeration in progress
//   err                 one-cycle pulse on a rejected request
//   chk_err             sticky popcount self-check failure
//
// Build option: define CLASS6_WEIGHT_CHECK_EN to include the popcount self-checker.
// Without it chk_err is tied low and the checker logic is absent.

module class6_weight_enum #(
  parameter int N = 7,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_weight,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_word,
  output logic         out_last,
  output logic         busy,
  output logic         err,
  output logic         chk_err
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] k_q, k_d;
  logic [N-1:0] word_q, word_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  // Smallest word of weight k: k ones packed at bit 0.
  function automatic logic [N-1:0] first_word(input logic [W-1:0] k);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(k)) w[i] = 1'b1;
    end
    return w;
  endfunction

  // Largest word of weight k: k ones packed at the top.
  function automatic logic [N-1:0] final_word(input logic [W-1:0] k);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (i + int'(k) >= N) w[i] = 1'b1;
    end
    return w;
  endfunction

  // Next larger word of equal weight. Adding the lowest set bit carries the
  // lowest run of ones up by one position; the bits that flipped are the old
  // run plus the new top bit, so shifting them down by (tz + 2) leaves
  // exactly (run length - 1) ones packed at bit 0. Only called on non-final
  // words, so the addition never overflows N bits.
  function automatic logic [N-1:0] next_word(input logic [N-1:0] x);
    logic [N-1:0] lo;
    logic [N-1:0] sum;
    logic [N-1:0] ripple;
    int           tz;
    tz = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (x[i]) tz = i;
    end
    lo     = x & (~x + N'(1));
    sum    = x + lo;
    ripple = (sum ^ x) >> (tz + 2);
    return sum | ripple;
  endfunction

  logic [N-1:0] nxt_word;
  logic [N-1:0] req_first;
  logic [N-1:0] req_final;
  logic [N-1:0] cur_final;
  logic         weight_ok;

  always_comb begin
    nxt_word  = next_word(word_q);
    req_first = first_word(req_weight);
    req_final = final_word(req_weight);
    cur_final = final_word(k_q);
    weight_ok = (32'(req_weight) <= 32'(N));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (weight_ok) begin
            state_d = EMIT;
            k_d     = req_weight;
            word_d  = req_first;
            // Only k=0 and k=N have first == final.
            last_d  = (req_first == req_final);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            word_d = nxt_word;
            last_d = (nxt_word == cur_final);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign err       = err_q;

`ifdef CLASS6_WEIGHT_CHECK_EN
  // Staged popcount: each stage folds one more bit of the word into the
  // running count, mirroring the class6 adder chain generalised to N bits.
  logic [W-1:0] pop_stage [N+1];
  logic         chk_err_q, chk_err_d;

  always_comb begin
    pop_stage[0] = '0;
    for (int i = 0; i < N; i++) begin
      pop_stage[i+1] = pop_stage[i] + {{(W-1){1'b0}}, word_q[i]};
    end
  end

  always_comb begin
    chk_err_d = chk_err_q;
    if (valid_q && (pop_stage[N] != k_q)) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_class6_weight_enum.sv
module tb_class6_weight_enum;

  localparam int N = 7;
  // Weight field one bit wider than strictly needed so that an out-of-range
  // weight (8) can actually be presented to the block.
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_weight;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_word;
  logic         out_last;
  logic         busy;
  logic         err;
  logic         chk_err;

  int total;
  int bad;

  class6_weight_enum #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_weight(req_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Smallest value above v with popcount k (brute-force scan, independent of the DUT's method).
  function automatic logic [N-1:0] next_exp(input logic [N-1:0] v, input int k);
    logic [N-1:0] c;
    for (int i = int'(v) + 1; i < (1 << N); i++) begin
      c = N'(i);
      if ($countones(c) == k) return c;
    end
    return '0;
  endfunction

  task automatic send_req(input int k);
    req_valid  = 1'b1;
    req_weight = W'(k);
    tick;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_word !== 7'd0) begin bad++; $display("FAIL reset_out_word got=%b want=0000000", out_word); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL reset_chk_err got=%b want=0", chk_err); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_k2;
    int           n;
    logic [N-1:0] exp;
    bit           done;
    out_ready = 1'b1;
    send_req(2);
    total++; if (out_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL k2_start valid=%b busy=%b req_ready=%b want 1 1 0", out_valid, busy, req_ready);
    end
    exp = 7'b0000011;
    n = 0;
    done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL k2_bubble cycle=%0d out_valid=%b want=1", cyc, out_valid); end
      if (out_valid === 1'b1) begin
        total++; if (out_word !== exp) begin bad++; $display("FAIL k2_word idx=%0d got=%b want=%b", n, out_word, exp); end
        total++; if (out_last !== (n == 20)) begin bad++; $display("FAIL k2_last idx=%0d got=%b want=%b", n, out_last, (n == 20)); end
        if (out_last === 1'b1) done = 1;
        n++;
        exp = next_exp(exp, 2);
      end
      tick;
    end
    total++; if (n != 21) begin bad++; $display("FAIL k2_count got=%0d want=21", n); end
    total++; if (req_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL k2_idle req_ready=%b out_valid=%b busy=%b want 1 0 0", req_ready, out_valid, busy);
    end
  endtask

  task automatic test_single_word;
    out_ready = 1'b1;
    send_req(0);
    total++; if (out_valid !== 1'b1 || out_word !== 7'b0000000 || out_last !== 1'b1) begin
      bad++; $display("FAIL k0_word valid=%b word=%b last=%b want 1 0000000 1", out_valid, out_word, out_last);
    end
    tick;
    total++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL k0_idle valid=%b req_ready=%b want 0 1", out_valid, req_ready);
    end
    send_req(7);
    total++; if (out_valid !== 1'b1 || out_word !== 7'b1111111 || out_last !== 1'b1) begin
      bad++; $display("FAIL k7_word valid=%b word=%b last=%b want 1 1111111 1", out_valid, out_word, out_last);
    end
    tick;
    total++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL k7_idle valid=%b req_ready=%b want 0 1", out_valid, req_ready);
    end
  endtask

  task automatic test_bad_weight;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_pre_err got=%b want=0", err); end
    send_req(8);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err_pulse got=%b want=1", err); end
    total++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bad_state valid=%b req_ready=%b want 0 1", out_valid, req_ready);
    end
    tick;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_clear got=%b want=0", err); end
    total++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bad_after valid=%b req_ready=%b want 0 1", out_valid, req_ready);
    end
  endtask

  task automatic test_k3_backpressure;
    int           n;
    logic [N-1:0] exp;
    logic [N-1:0] held_word;
    logic         held_last;
    bit           stalled;
    bit           done;
    out_ready = 1'b0;
    send_req(3);
    exp = 7'b0000111;
    n = 0;
    stalled = 0;
    done = 0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      if (stalled) begin
        total++; if (out_word !== held_word || out_last !== held_last) begin
          bad++; $display("FAIL k3_hold got=%b/%b want=%b/%b", out_word, out_last, held_word, held_last);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      stalled = (out_valid === 1'b1) && !out_ready;
      held_word = out_word;
      held_last = out_last;
      if (out_valid === 1'b1 && out_ready) begin
        total++; if (out_word !== exp) begin bad++; $display("FAIL k3_word idx=%0d got=%b want=%b", n, out_word, exp); end
        total++; if (out_last !== (n == 34)) begin bad++; $display("FAIL k3_last idx=%0d got=%b want=%b", n, out_last, (n == 34)); end
        if (out_last === 1'b1) done = 1;
        n++;
        exp = next_exp(exp, 3);
      end
      tick;
    end
    out_ready = 1'b1;
    total++; if (n != 35) begin bad++; $display("FAIL k3_count got=%0d want=35", n); end
    total++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL k3_idle req_ready=%b valid=%b want 1 0", req_ready, out_valid);
    end
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL k3_chk_err got=%b want=0", chk_err); end
  endtask

  task automatic test_reset_mid_stream;
    int           hs;
    int           n;
    logic [N-1:0] exp;
    bit           done;
    out_ready = 1'b1;
    send_req(4);
    hs = 0;
    for (int cyc = 0; cyc < 50 && hs < 5; cyc++) begin
      if (out_valid === 1'b1) hs++;
      tick;
    end
    total++; if (hs != 5) begin bad++; $display("FAIL rst_mid_handshakes got=%0d want=5", hs); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_state valid=%b busy=%b req_ready=%b want 0 0 1", out_valid, busy, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet cycle=%0d valid=%b want=0", i, out_valid); end
    end
    send_req(1);
    exp = 7'b0000001;
    n = 0;
    done = 0;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      if (out_valid === 1'b1) begin
        total++; if (out_word !== exp) begin bad++; $display("FAIL k1_word idx=%0d got=%b want=%b", n, out_word, exp); end
        if (out_last === 1'b1) done = 1;
        n++;
        exp = exp << 1;
      end
      tick;
    end
    total++; if (n != 7) begin bad++; $display("FAIL k1_count got=%0d want=7", n); end
  endtask

  task automatic test_self_check;
`ifdef CLASS6_WEIGHT_CHECK_EN
    out_ready = 1'b0;
    send_req(3);
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_clean got=%b want=0", chk_err); end
    // Corrupt the held word to weight 4 while k=3.
    force dut.word_q = 7'b0001111;
    tick;
    release dut.word_q;
    total++; if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_set got=%b want=1", chk_err); end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_sticky cycle=%0d got=%b want=1", i, chk_err); end
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_cleared got=%b want=0", chk_err); end
    out_ready = 1'b1;
`else
    tick;
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_tied got=%b want=0", chk_err); end
`endif
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_weight = '0;
    out_ready  = 1'b0;
    test_reset;
    test_k2;
    test_single_word;
    test_bad_weight;
    test_k3_backpressure;
    test_reset_mid_stream;
    test_self_check;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
